execute_stage: RTL and testbench

//  EX stage of the 5-stage MIPS R2000 pipeline, between ID and MEM.
//  ALU ops and operand select. Destination register select.

---
 rtl/mips_pkg.sv | 56 +++++
 rtl/mdu_unit.sv | 137 +++++++++++++
 rtl/execute_stage.sv | 119 +++++++++++
 tb/tb_execute_stage.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS R2000 execute stage.
// Holds the ALU/MDU opcode enum, the MDU state enum, the EX/MEM payload struct
// and a decode helper for iterative mult/div operations.
// Optional feature macro: MDU_DIV_EN (enables DIV/DIVU in the MDU).
package mips_pkg;

  localparam int unsigned WIDTH     = 32;
  localparam int unsigned REG_AW    = 5;
  localparam int unsigned MDU_STEPS = 32;  // must equal WIDTH
  localparam int unsigned CNT_W     = $clog2(MDU_STEPS);

  typedef enum logic [3:0] {
    OP_AND   = 4'd0,
    OP_OR    = 4'd1,
    OP_ADD   = 4'd2,
    OP_SUB   = 4'd3,
    OP_SLT   = 4'd4,
    OP_NOR   = 4'd5,
    OP_XOR   = 4'd6,
    OP_SLL   = 4'd7,
    OP_SRL   = 4'd8,
    OP_SRA   = 4'd9,
    OP_MULT  = 4'd10,
    OP_MULTU = 4'd11,
    OP_DIV   = 4'd12,
    OP_DIVU  = 4'd13,
    OP_MFHI  = 4'd14,
    OP_MFLO  = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_e;

  // EX/MEM pipeline register payload
  typedef struct packed {
    logic [1:0]        wb;
    logic [2:0]        m;
    logic              zero;
    logic [WIDTH-1:0]  addr;
    logic [WIDTH-1:0]  wdata;
    logic [REG_AW-1:0] wreg;
  } ex_mem_t;

  // Ops that occupy the iterative MDU (divides only when the divider is built)
  function automatic logic is_mdu_op(alu_op_e op);
`ifdef MDU_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/mdu_unit.sv
// Iterative multiply/divide unit owning HI/LO.
// One shift-add (multiply) or restoring-divide step per cycle, MDU_STEPS steps.
// Signed ops run on magnitudes; signs are applied as HI/LO are written.
// Ports: clk, rst_n; start_i (accept op in IDLE), op_i, a_i (rs), b_i (rt);
//        busy_o (BUSY), done_o (DONE), hi_o, lo_o (architectural HI/LO).
// Optional feature macro: MDU_DIV_EN (divider datapath).
module mdu_unit
  import mips_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  alu_op_e          op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int unsigned PW = 2 * WIDTH;

  mdu_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [PW-1:0]    acc_q, acc_d;   // {partial/remainder, multiplier/quotient}
  logic [WIDTH-1:0] mcand_q;        // multiplicand or divisor magnitude
  logic             neg_lo_q;       // product sign, or quotient sign for divides
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;

  logic             signed_op, a_neg, b_neg;
  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH:0]   add_sum;

`ifdef MDU_DIV_EN
  logic           is_div_q, neg_hi_q, div_start;
  logic [WIDTH:0] div_shift, div_diff;
  assign div_start = (op_i == OP_DIV) || (op_i == OP_DIVU);
`endif

  // Operand magnitudes for signed ops
  assign signed_op = (op_i == OP_MULT) || (op_i == OP_DIV);
  assign a_neg     = signed_op & a_i[WIDTH-1];
  assign b_neg     = signed_op & b_i[WIDTH-1];
  assign a_mag     = a_neg ? WIDTH'(-a_i) : a_i;
  assign b_mag     = b_neg ? WIDTH'(-b_i) : b_i;

  // One iteration step
  always_comb begin
    acc_d   = acc_q;
    add_sum = '0;
`ifdef MDU_DIV_EN
    div_shift = '0;
    div_diff  = '0;
    if (is_div_q) begin
      // Restoring step: bring in next dividend bit, subtract if it fits
      div_shift = {acc_q[PW-1:WIDTH], acc_q[WIDTH-1]};
      div_diff  = div_shift - {1'b0, mcand_q};
      if (!div_diff[WIDTH]) acc_d = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
      else                  acc_d = {div_shift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0};
    end else
`endif
    begin
      add_sum = {1'b0, acc_q[PW-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
      acc_d   = {add_sum, acc_q[WIDTH-1:1]};
    end
  end

  // Sign fix-up of the final step's result
  always_comb begin
    hi_d = acc_d[PW-1:WIDTH];
    lo_d = acc_d[WIDTH-1:0];
`ifdef MDU_DIV_EN
    if (is_div_q) begin
      lo_d = neg_lo_q ? WIDTH'(-acc_d[WIDTH-1:0]) : acc_d[WIDTH-1:0];
      hi_d = neg_hi_q ? WIDTH'(-acc_d[PW-1:WIDTH]) : acc_d[PW-1:WIDTH];
    end else
`endif
    if (neg_lo_q) {hi_d, lo_d} = PW'(-acc_d);
  end

  // MDU FSM, counter and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= MDU_IDLE;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      neg_lo_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
`ifdef MDU_DIV_EN
      is_div_q <= 1'b0;
      neg_hi_q <= 1'b0;
`endif
    end else begin
      unique case (state_q)
        MDU_IDLE: begin
          if (start_i) begin
            state_q  <= MDU_BUSY;
            cnt_q    <= '0;
            neg_lo_q <= a_neg ^ b_neg;
`ifdef MDU_DIV_EN
            is_div_q <= div_start;
            neg_hi_q <= a_neg;
            if (div_start) begin
              acc_q   <= {{WIDTH{1'b0}}, a_mag};
              mcand_q <= b_mag;
            end else
`endif
            begin
              acc_q   <= {{WIDTH{1'b0}}, b_mag};
              mcand_q <= a_mag;
            end
          end
        end
        MDU_BUSY: begin
          acc_q <= acc_d;
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_W'(MDU_STEPS - 1)) begin
            state_q <= MDU_DONE;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
          end
        end
        MDU_DONE: state_q <= MDU_IDLE;
        default:  state_q <= MDU_IDLE;
      endcase
    end
  end

  assign busy_o = (state_q == MDU_BUSY);
  assign done_o = (state_q == MDU_DONE);
  assign hi_o   = hi_q;
  assign lo_o   = lo_q;

endmodule

// File: rtl/execute_stage.sv
// EX stage of the 5-stage MIPS R2000 pipeline (between ID and MEM).
// ALU, operand-B and destination muxes, stall generation for the iterative
// MDU, and the EX/MEM register driving MEM.
// Ports: clk, rst_n; ID/EX inputs wb_ex, m_ex, alu_ctrl, alu_src, reg_dst,
//        read_data_1/2, imm_ex, shamt_ex, rt_ex, rd_ex;
//        stall to hazard unit (combinational);
//        EX/MEM outputs wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex.
// Optional feature macro: MDU_DIV_EN (DIV/DIVU; otherwise they retire as bubbles).
module execute_stage
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        wb_ex,
  input  logic [2:0]        m_ex,
  input  logic [3:0]        alu_ctrl,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic [WIDTH-1:0]  read_data_1,
  input  logic [WIDTH-1:0]  read_data_2,
  input  logic [WIDTH-1:0]  imm_ex,
  input  logic [4:0]        shamt_ex,
  input  logic [REG_AW-1:0] rt_ex,
  input  logic [REG_AW-1:0] rd_ex,
  output logic              stall,
  output logic [1:0]        wb_MEM,
  output logic [2:0]        m,
  output logic              zero,
  output logic [WIDTH-1:0]  address_MEM,
  output logic [WIDTH-1:0]  write_data_mem,
  output logic [REG_AW-1:0] write_register_ex
);

  alu_op_e           op;
  logic [WIDTH-1:0]  op_b, result, hi, lo;
  logic [REG_AW-1:0] dest;
  logic              mdu_busy, mdu_done, mdu_idle, mdu_start, mf_op, div_nop;
  ex_mem_t           exm_q, exm_d;

  assign op   = alu_op_e'(alu_ctrl);
  assign op_b = alu_src ? imm_ex : read_data_2;
  assign dest = reg_dst ? rd_ex : rt_ex;

  mdu_unit u_mdu (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (mdu_start),
    .op_i    (op),
    .a_i     (read_data_1),
    .b_i     (read_data_2),
    .busy_o  (mdu_busy),
    .done_o  (mdu_done),
    .hi_o    (hi),
    .lo_o    (lo)
  );

  assign mdu_idle  = !mdu_busy && !mdu_done;
  assign mdu_start = mdu_idle && is_mdu_op(op);
  assign mf_op     = (op == OP_MFHI) || (op == OP_MFLO);

`ifdef MDU_DIV_EN
  assign div_nop = 1'b0;
`else
  assign div_nop = (op == OP_DIV) || (op == OP_DIVU);
`endif

  // Hold ID/EX while an MDU op is accepted or running, or HI/LO are not yet final
  assign stall = rst_n && (mdu_start || mdu_busy || (mf_op && !mdu_idle));

  // Single-cycle ALU; MDU ops themselves produce no address
  always_comb begin
    result = '0;
    unique case (op)
      OP_AND:  result = read_data_1 & op_b;
      OP_OR:   result = read_data_1 | op_b;
      OP_ADD:  result = read_data_1 + op_b;
      OP_SUB:  result = read_data_1 - op_b;
      OP_SLT:  result = {{(WIDTH-1){1'b0}}, ($signed(read_data_1) < $signed(op_b))};
      OP_NOR:  result = ~(read_data_1 | op_b);
      OP_XOR:  result = read_data_1 ^ op_b;
      OP_SLL:  result = op_b << shamt_ex;
      OP_SRL:  result = op_b >> shamt_ex;
      OP_SRA:  result = WIDTH'($signed(op_b) >>> shamt_ex);
      OP_MFHI: result = hi;
      OP_MFLO: result = lo;
      default: result = '0;
    endcase
  end

  // EX/MEM next state: bubble (address held) while stalled or on a disabled divide
  always_comb begin
    exm_d = exm_q;
    if (stall || div_nop) begin
      exm_d.wb   = '0;
      exm_d.m    = '0;
      exm_d.wreg = '0;
    end else begin
      exm_d.wb    = wb_ex;
      exm_d.m     = m_ex;
      exm_d.zero  = (result == '0);
      exm_d.addr  = result;
      exm_d.wdata = read_data_2;
      exm_d.wreg  = dest;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) exm_q <= '0;
    else        exm_q <= exm_d;
  end

  assign wb_MEM            = exm_q.wb;
  assign m                 = exm_q.m;
  assign zero              = exm_q.zero;
  assign address_MEM       = exm_q.addr;
  assign write_data_mem    = exm_q.wdata;
  assign write_register_ex = exm_q.wreg;

endmodule

// File: tb/tb_execute_stage.sv
// Self-checking bench for execute_stage: table of single-cycle ALU vectors,
// plus sequences for mult/div stalls, bubbles, reset abort and divide config.
module tb_execute_stage;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  wb_ex;
  logic [2:0]  m_ex;
  logic [3:0]  alu_ctrl;
  logic        alu_src, reg_dst;
  logic [31:0] read_data_1, read_data_2, imm_ex;
  logic [4:0]  shamt_ex, rt_ex, rd_ex;
  logic        stall, zero;
  logic [1:0]  wb_MEM;
  logic [2:0]  m;
  logic [31:0] address_MEM, write_data_mem;
  logic [4:0]  write_register_ex;

  execute_stage dut (
    .clk(clk), .rst_n(rst_n), .wb_ex(wb_ex), .m_ex(m_ex), .alu_ctrl(alu_ctrl),
    .alu_src(alu_src), .reg_dst(reg_dst), .read_data_1(read_data_1),
    .read_data_2(read_data_2), .imm_ex(imm_ex), .shamt_ex(shamt_ex),
    .rt_ex(rt_ex), .rd_ex(rd_ex), .stall(stall), .wb_MEM(wb_MEM), .m(m),
    .zero(zero), .address_MEM(address_MEM), .write_data_mem(write_data_mem),
    .write_register_ex(write_register_ex)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic        src, dst;
    logic [31:0] rd1, rd2, imm;
    logic [4:0]  sh, rt, rd;
    logic [1:0]  wb;
    logic [2:0]  m;
    logic [31:0] res;
  } vec_t;

  typedef struct {
    logic [1:0]  wb;
    logic [2:0]  m;
    logic        zero;
    logic [31:0] addr, wdata;
    logic [4:0]  wreg;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_addr = '0;
  logic [31:0] hi_m = '0, lo_m = '0;
  vec_t        tbl[13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] op, input logic src, input logic dst,
                              input logic [31:0] rd1, input logic [31:0] rd2,
                              input logic [31:0] imm, input logic [4:0] sh,
                              input logic [4:0] rt, input logic [4:0] rd,
                              input logic [1:0] wb, input logic [2:0] mm,
                              input logic [31:0] res);
    vec_t v;
    v.op = op; v.src = src; v.dst = dst; v.rd1 = rd1; v.rd2 = rd2; v.imm = imm;
    v.sh = sh; v.rt = rt; v.rd = rd; v.wb = wb; v.m = mm; v.res = res;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    alu_ctrl = v.op; alu_src = v.src; reg_dst = v.dst;
    read_data_1 = v.rd1; read_data_2 = v.rd2; imm_ex = v.imm;
    shamt_ex = v.sh; rt_ex = v.rt; rd_ex = v.rd; wb_ex = v.wb; m_ex = v.m;
  endtask

  // Single-cycle op: expectation pushed at issue, popped when EX/MEM updates
  task automatic issue(input vec_t v, input string name);
    exp_t e;
    @(negedge clk);
    drive(v);
    e.wb = v.wb; e.m = v.m; e.zero = (v.res == 32'd0); e.addr = v.res;
    e.wdata = v.rd2; e.wreg = v.dst ? v.rd : v.rt;
    sb.push_back(e);
    #1 chk({name, "_stall"}, stall, 1'b0);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({name, "_addr"},  address_MEM, e.addr);
    chk({name, "_zero"},  zero, e.zero);
    chk({name, "_wreg"},  write_register_ex, e.wreg);
    chk({name, "_wb_m"},  {wb_MEM, m}, {e.wb, e.m});
    chk({name, "_wdata"}, write_data_mem, e.wdata);
    last_addr = e.addr;
  endtask

  task automatic read_hilo(input string name);
    issue(mk(OP_MFLO, 0, 1, 0, 0, 0, 0, 0, 5, 2'b10, 3'b000, lo_m), {name, "_mflo"});
    issue(mk(OP_MFHI, 0, 1, 0, 0, 0, 0, 0, 6, 2'b10, 3'b000, hi_m), {name, "_mfhi"});
  endtask

  // Multi-cycle MDU op: stall length, bubbles with held address, retire pass-through
  task automatic run_mdu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input string name);
    int n;
    bit bub_ok;
    @(negedge clk);
    drive(mk(op, 0, 1, a, b, 0, 0, 0, 9, 2'b10, 3'b000, 0));
    #1 chk({name, "_stall_issue"}, stall, 1'b1);
    n = 0;
    bub_ok = 1'b1;
    while (stall && n < 200) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (wb_MEM !== 2'b00 || m !== 3'b000 || write_register_ex !== 5'd0 ||
          address_MEM !== last_addr) bub_ok = 1'b0;
    end
    chk({name, "_stall_cycles"}, n, MDU_STEPS + 1);
    chk({name, "_bubbles"}, bub_ok, 1'b1);
    @(posedge clk);
    #1 chk({name, "_retire"}, {wb_MEM, write_register_ex}, {2'b10, 5'd9});
  endtask

  initial begin
    logic signed [63:0] prod;
    bit stale;

    tbl[0]  = mk(OP_ADD, 0, 0, 5, 7, 0, 0, 4, 0, 2'b10, 3'b000, 32'd12);
    tbl[1]  = mk(OP_SUB, 0, 1, 9, 9, 0, 0, 4, 3, 2'b10, 3'b000, 32'd0);
    tbl[2]  = mk(OP_AND, 0, 1, 32'hFF00_FF00, 32'h0F0F_0F0F, 0, 0, 1, 2, 2'b11, 3'b000, 32'h0F00_0F00);
    tbl[3]  = mk(OP_OR,  0, 0, 32'hF0, 32'h0F, 0, 0, 7, 1, 2'b10, 3'b000, 32'hFF);
    tbl[4]  = mk(OP_NOR, 0, 1, 0, 0, 0, 0, 0, 31, 2'b10, 3'b000, 32'hFFFF_FFFF);
    tbl[5]  = mk(OP_XOR, 0, 1, 32'hAAAA_5555, 32'hFFFF_0000, 0, 0, 0, 8, 2'b10, 3'b000, 32'h5555_5555);
    tbl[6]  = mk(OP_SLT, 0, 1, 32'hFFFF_FFFF, 1, 0, 0, 0, 10, 2'b10, 3'b000, 32'd1);
    tbl[7]  = mk(OP_SLT, 0, 1, 1, 32'hFFFF_FFFF, 0, 0, 0, 11, 2'b10, 3'b000, 32'd0);
    tbl[8]  = mk(OP_SLL, 0, 1, 0, 1, 0, 31, 0, 12, 2'b10, 3'b000, 32'h8000_0000);
    tbl[9]  = mk(OP_SRL, 0, 1, 0, 32'h8000_0000, 0, 4, 0, 13, 2'b10, 3'b000, 32'h0800_0000);
    tbl[10] = mk(OP_SRA, 0, 1, 0, 32'h8000_0000, 0, 4, 0, 14, 2'b10, 3'b000, 32'hF800_0000);
    tbl[11] = mk(OP_ADD, 1, 0, 32'hFFFF_FFFF, 32'h1234, 1, 0, 15, 0, 2'b01, 3'b001, 32'd0);
    tbl[12] = mk(OP_SUB, 0, 0, 0, 1, 0, 0, 16, 0, 2'b11, 3'b010, 32'hFFFF_FFFF);

    // Reset with live inputs: everything must read 0
    rst_n = 1'b0;
    drive(mk(OP_MULT, 0, 1, 3, 4, 0, 0, 1, 2, 2'b11, 3'b011, 0));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_stall", stall, 1'b0);
    chk("reset_outs", {wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex}, '0);
    @(negedge clk);
    drive(mk(OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
    rst_n = 1'b1;

    for (int i = 0; i < 13; i++) issue(tbl[i], $sformatf("vec%0d", i));

    // MULT -3 x 4
    issue(tbl[0], "pre_mult");
    prod = 64'(-64'sd3 * 64'sd4);
    run_mdu(OP_MULT, 32'hFFFF_FFFD, 32'd4, "mult");
    hi_m = prod[63:32]; lo_m = prod[31:0];
    read_hilo("mult");

    // MULTU with full-width operands
    run_mdu(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "multu");
    hi_m = 32'hFFFF_FFFE; lo_m = 32'h0000_0001;
    read_hilo("multu");

`ifdef MDU_DIV_EN
    run_mdu(OP_DIVU, 32'd100, 32'd7, "divu");
    lo_m = 32'd100 / 32'd7; hi_m = 32'd100 % 32'd7;
    read_hilo("divu");
    run_mdu(OP_DIVU, 32'd5, 32'd0, "divu0");
    lo_m = 32'hFFFF_FFFF; hi_m = 32'd5;
    read_hilo("divu0");
    run_mdu(OP_DIV, 32'hFFFF_FFF9, 32'd2, "div_neg");
    lo_m = 32'hFFFF_FFFD; hi_m = 32'hFFFF_FFFF;
    read_hilo("div_neg");
`else
    // Divide disabled: bubble to MEM, no stall, HI/LO untouched
    issue(mk(OP_ADD, 0, 0, 1, 2, 0, 0, 3, 0, 2'b10, 3'b000, 32'd3), "pre_div");
    @(negedge clk);
    drive(mk(OP_DIV, 0, 1, 50, 5, 0, 0, 0, 7, 2'b11, 3'b010, 0));
    #1 chk("divnop_stall", stall, 1'b0);
    @(posedge clk);
    #1 chk("divnop_bubble", {wb_MEM, m, write_register_ex, address_MEM}, {2'b00, 3'b000, 5'd0, 32'd3});
    @(negedge clk);
    alu_ctrl = OP_DIVU;
    #1 chk("divunop_stall", stall, 1'b0);
    read_hilo("divnop");
`endif

    // Reset 10 cycles into a MULT aborts it
    run_mdu(OP_MULT, 32'd7, 32'd6, "mult2");
    hi_m = 32'd0; lo_m = 32'd42;
    read_hilo("mult2");
    @(negedge clk);
    drive(mk(OP_MULT, 0, 1, 32'h1234, 32'h5678, 0, 0, 0, 9, 2'b10, 3'b000, 0));
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("abort_mid_stall", stall, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("abort_stall", stall, 1'b0);
    chk("abort_outs", {wb_MEM, m, zero, address_MEM, write_data_mem, write_register_ex}, '0);
    drive(mk(OP_AND, 0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 3'b000, 0));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    stale = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (stall !== 1'b0) stale = 1'b1;
    end
    chk("abort_no_stale", stale, 1'b0);
    hi_m = 32'd0; lo_m = 32'd0;
    read_hilo("abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1);
  end

endmodule
